// File: rtl/serial_compare_sequencer.sv
// Feeds operand pairs bit-serially (LSB first) into a serial magnitude comparator and holds its verdict.
// Optional macro CMP_CHECK_EN adds a sticky err output that cross-checks the comparator against a parallel compare.
module serial_compare_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cmp_rst,
  output logic             cmp_op,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_L,
  input  logic             cmp_E,
  input  logic             cmp_G,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_L,
  output logic             res_E,
  output logic             res_G
`ifdef CMP_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST    = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] LAST_M1 = IDXW'((WIDTH > 1) ? (WIDTH - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_CAPT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW-1:0]  w_nextIdx;
  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic [WIDTH-1:0] w_nextShA;
  logic [WIDTH-1:0] w_nextShB;
  logic             w_nextOp;
  logic             w_nextA;
  logic             w_nextB;
  logic             w_capture;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign cmp_rst   = rst | (r_state == S_CLR);

  // The shift registers always hold the not-yet-driven bits at position 0, so the
  // serial outputs are registered one cycle ahead of the state that shows them.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_nextShA   = r_shA;
    w_nextShB   = r_shB;
    w_nextOp    = 1'b0;
    w_nextA     = 1'b0;
    w_nextB     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_nextShA   = a_in;
          w_nextShB   = b_in;
          w_nextIdx   = '0;
          w_nextState = S_CLR;
        end
      end
      S_CLR: begin
        w_nextA     = r_shA[0];
        w_nextB     = r_shB[0];
        w_nextOp    = (r_idx == LAST);
        w_nextShA   = r_shA >> 1;
        w_nextShB   = r_shB >> 1;
        w_nextState = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_idx == LAST) begin
          w_nextState = S_CAPT;
        end else begin
          w_nextA   = r_shA[0];
          w_nextB   = r_shB[0];
          w_nextOp  = (r_idx == LAST_M1);
          w_nextShA = r_shA >> 1;
          w_nextShB = r_shB >> 1;
          w_nextIdx = r_idx + IDXW'(1);
        end
      end
      S_CAPT: begin
        w_capture   = 1'b1;
        w_nextState = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_shA   <= '0;
      r_shB   <= '0;
      cmp_op  <= 1'b0;
      cmp_a   <= 1'b0;
      cmp_b   <= 1'b0;
      res_L   <= 1'b0;
      res_E   <= 1'b0;
      res_G   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_nextIdx;
      r_shA   <= w_nextShA;
      r_shB   <= w_nextShB;
      cmp_op  <= w_nextOp;
      cmp_a   <= w_nextA;
      cmp_b   <= w_nextB;
      if (w_capture) begin
        res_L <= cmp_L;
        res_E <= cmp_E;
        res_G <= cmp_G;
      end
    end
  end

`ifdef CMP_CHECK_EN
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic             w_refL;
  logic             w_refE;
  logic             w_refG;
  logic             w_oneHot;
  logic             w_bad;

  assign w_refL   = (r_opA < r_opB);
  assign w_refE   = (r_opA == r_opB);
  assign w_refG   = (r_opA > r_opB);
  assign w_oneHot = (cmp_L ^ cmp_E ^ cmp_G) & ~(cmp_L & cmp_E & cmp_G);
  assign w_bad    = ({cmp_L, cmp_E, cmp_G} != {w_refL, w_refE, w_refG}) | ~w_oneHot;

  // Parallel copy of the operands survives the serial shift-out for the cross-check.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA <= '0;
      r_opB <= '0;
      err   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && in_valid) begin
        r_opA <= a_in;
        r_opB <= b_in;
      end
      if (w_capture && w_bad) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Self-checking bench for serial_compare_sequencer with a behavioural serial comparator attached.
// Define CMP_CHECK_EN to also exercise the err cross-check with a faulty comparator stub.
module tb_serial_compare_sequencer;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cmp_rst;
   logic         cmp_op;
   logic         cmp_a;
   logic         cmp_b;
   logic         cmp_L;
   logic         cmp_E;
   logic         cmp_G;
   logic         out_valid;
   logic         out_ready;
   logic         res_L;
   logic         res_E;
   logic         res_G;
`ifdef CMP_CHECK_EN
   logic         err;
`endif

   int checks;
   int failures;
   bit forceL;

   serial_compare_sequencer #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a_in(a_in),
      .b_in(b_in),
      .cmp_rst(cmp_rst),
      .cmp_op(cmp_op),
      .cmp_a(cmp_a),
      .cmp_b(cmp_b),
      .cmp_L(cmp_L),
      .cmp_E(cmp_E),
      .cmp_G(cmp_G),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .res_L(res_L),
      .res_E(res_E),
      .res_G(res_G)
`ifdef CMP_CHECK_EN
      ,
      .err(err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serial comparator: later (more significant) differing bits override earlier ones.
   int mState;
   always @(posedge clk) begin
      if (cmp_rst) mState <= 0;
      else if (cmp_a && !cmp_b) mState <= 2;
      else if (!cmp_a && cmp_b) mState <= 1;
   end
   assign cmp_L = (mState == 1) || forceL;
   assign cmp_E = (mState == 0);
   assign cmp_G = (mState == 2);

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   expLEG;
      int           hold;
   } vec_t;

   vec_t vecs[9];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Waits (bounded) for in_ready, presents a pair and returns right after the accept edge.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a_in = a;
      b_in = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_in = W'($urandom);
      b_in = W'($urandom);
   endtask

   // Observes one operation from the accept edge through the result handshake.
   task automatic monitorOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] expLEG,
                            input int hold, input string tag);
      logic [W-1:0] ta;
      logic [W-1:0] tb;
      int opCnt, opIdx, lat;
      bit busyReady, clrSeen, holdBad;
      ta = '0; tb = '0; opCnt = 0; opIdx = -1; lat = -1;
      busyReady = 0; clrSeen = 0; holdBad = 0;
      out_ready = (hold == 0);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
         if (in_ready) busyReady = 1;
         if (k == 0) clrSeen = cmp_rst;
         if (k >= 1 && k <= W) begin
            ta[k-1] = cmp_a;
            tb[k-1] = cmp_b;
            if (cmp_op) begin
               opCnt++;
               opIdx = k - 1;
            end
         end else if (cmp_op) begin
            opCnt++;
         end
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(W + 2));
      checkOutput({tag, "_clr"}, 32'(clrSeen), 32'd1);
      checkOutput({tag, "_traceA"}, 32'(ta), 32'(a));
      checkOutput({tag, "_traceB"}, 32'(tb), 32'(b));
      checkOutput({tag, "_opCount"}, 32'(opCnt), 32'd1);
      checkOutput({tag, "_opIdx"}, 32'(opIdx), 32'(W - 1));
      checkOutput({tag, "_busyReady"}, 32'(busyReady), 32'd0);
      checkOutput({tag, "_res"}, 32'({res_L, res_E, res_G}), 32'(expLEG));
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid || in_ready || ({res_L, res_E, res_G} !== expLEG)) holdBad = 1;
         end
         checkOutput({tag, "_holdStable"}, 32'(holdBad), 32'd0);
         out_ready = 1'b1;
      end
      @(negedge clk);
      checkOutput({tag, "_backToIdle"}, 32'({in_ready, out_valid}), 32'b10);
      checkOutput({tag, "_resKept"}, 32'({res_L, res_E, res_G}), 32'(expLEG));
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      checks = 0;
      failures = 0;
      forceL = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      a_in = '0;
      b_in = '0;
      out_ready = 1'b1;

      vecs[0] = '{8'h05, 8'h09, 3'b100, 0};
      vecs[1] = '{8'hA5, 8'hA5, 3'b010, 0};
      vecs[2] = '{8'h80, 8'h7F, 3'b001, 5};
      vecs[3] = '{8'h7F, 8'h80, 3'b100, 0};
      vecs[4] = '{8'h00, 8'h00, 3'b010, 0};
      vecs[5] = '{8'hFF, 8'h00, 3'b001, 1};
      vecs[6] = '{8'h00, 8'hFF, 3'b100, 0};
      vecs[7] = '{8'h01, 8'h80, 3'b100, 0};
      vecs[8] = '{8'hFE, 8'hFF, 3'b100, 2};

      repeat (2) @(negedge clk);
      checkOutput("reset_cmpRstFollows", 32'(cmp_rst), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("reset_cmpRstLow", 32'(cmp_rst), 32'd0);
      checkOutput("reset_handshake", 32'({in_ready, out_valid}), 32'b10);
      checkOutput("reset_res", 32'({res_L, res_E, res_G}), 32'd0);
      checkOutput("reset_serial", 32'({cmp_op, cmp_a, cmp_b}), 32'd0);
`ifdef CMP_CHECK_EN
      checkOutput("reset_err", 32'(err), 32'd0);
`endif

      $display("[TB] directed vectors");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b);
         monitorOp(vecs[i].a, vecs[i].b, vecs[i].expLEG, vecs[i].hold, $sformatf("vec%0d", i));
      end

      $display("[TB] reset during shift");
      applyStimulus(8'h3C, 8'h5A);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_cmpRst", 32'(cmp_rst), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_handshake", 32'({in_ready, out_valid}), 32'b10);
      checkOutput("midrst_res", 32'({res_L, res_E, res_G}), 32'd0);
      checkOutput("midrst_serial", 32'({cmp_op, cmp_a, cmp_b}), 32'd0);
      applyStimulus(8'h10, 8'h01);
      monitorOp(8'h10, 8'h01, 3'b001, 0, "postrst");

      $display("[TB] random operands");
      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         applyStimulus(ra, rb);
         monitorOp(ra, rb, {ra < rb, ra == rb, ra > rb}, $urandom_range(0, 2), $sformatf("rnd%0d", i));
      end

`ifdef CMP_CHECK_EN
      $display("[TB] faulty comparator stub");
      forceL = 1;
      applyStimulus(8'h33, 8'h33);
      monitorOp(8'h33, 8'h33, 3'b110, 0, "stub");
      checkOutput("stub_err", 32'(err), 32'd1);
      forceL = 0;
      applyStimulus(8'h12, 8'h34);
      monitorOp(8'h12, 8'h34, 3'b100, 0, "afterStub");
      checkOutput("sticky_err", 32'(err), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("err_cleared", 32'(err), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
